// File: rtl/rvj1_dec_q_if.sv
// ---------------------------------------------------------------------------
// rvj1_dec_q_if -- bus bundle for the RV32I decode queue.
//
// Also declares the two enumerations shared by the decoder and whoever
// consumes its output:
//   alu_op_e   -- ALU operation selector
//   lsu_ctrl_e -- load/store unit command
//
// Signal groups:
//   fetch side : ifu_instr_i, ifu_valid_i, ifu_ready_o
//   control    : flush_i
//   issue side : out_valid_o, out_ready_i
//   decoded    : rf_addr_a_o, rf_addr_b_o, alu_sel_o, rpa_or_pc_o,
//                rpb_or_imm_o, alu_write_rf_o, alu_regdest_o, immediate_o,
//                lsu_ctrl_valid_o, lsu_ctrl_o, lsu_regdest_o, illegal_o
//   status     : count_o
//
// Modports:
//   slave  -- the decode queue itself
//   master -- the environment (fetch unit + issue stage)
// ---------------------------------------------------------------------------

typedef enum logic [3:0] {
  ALU_OP_ADD  = 4'd0,
  ALU_OP_SUB  = 4'd1,
  ALU_OP_SLL  = 4'd2,
  ALU_OP_SLT  = 4'd3,
  ALU_OP_SLTU = 4'd4,
  ALU_OP_XOR  = 4'd5,
  ALU_OP_SRL  = 4'd6,
  ALU_OP_SRA  = 4'd7,
  ALU_OP_OR   = 4'd8,
  ALU_OP_AND  = 4'd9
} alu_op_e;

typedef enum logic [3:0] {
  LSU_NO_CMD = 4'd0,
  LSU_LB     = 4'd1,
  LSU_LH     = 4'd2,
  LSU_LW     = 4'd3,
  LSU_LBU    = 4'd4,
  LSU_LHU    = 4'd5,
  LSU_SB     = 4'd6,
  LSU_SH     = 4'd7,
  LSU_SW     = 4'd8
} lsu_ctrl_e;

interface rvj1_dec_q_if #(
  parameter int XLEN  = 32,
  parameter int RALEN = 5,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  // fetch side
  logic [XLEN-1:0]  ifu_instr_i;
  logic             ifu_valid_i;
  logic             ifu_ready_o;
  // control
  logic             flush_i;
  // issue side
  logic             out_valid_o;
  logic             out_ready_i;
  // decoded head entry
  logic [RALEN-1:0] rf_addr_a_o;
  logic [RALEN-1:0] rf_addr_b_o;
  alu_op_e          alu_sel_o;
  logic             rpa_or_pc_o;
  logic             rpb_or_imm_o;
  logic             alu_write_rf_o;
  logic [RALEN-1:0] alu_regdest_o;
  logic [XLEN-1:0]  immediate_o;
  logic             lsu_ctrl_valid_o;
  lsu_ctrl_e        lsu_ctrl_o;
  logic [RALEN-1:0] lsu_regdest_o;
  logic             illegal_o;
  // status
  logic [CW-1:0]    count_o;

  modport slave (
    input  ifu_instr_i, ifu_valid_i, flush_i, out_ready_i,
    output ifu_ready_o, out_valid_o,
    output rf_addr_a_o, rf_addr_b_o, alu_sel_o, rpa_or_pc_o, rpb_or_imm_o,
    output alu_write_rf_o, alu_regdest_o, immediate_o,
    output lsu_ctrl_valid_o, lsu_ctrl_o, lsu_regdest_o, illegal_o,
    output count_o
  );

  modport master (
    output ifu_instr_i, ifu_valid_i, flush_i, out_ready_i,
    input  ifu_ready_o, out_valid_o,
    input  rf_addr_a_o, rf_addr_b_o, alu_sel_o, rpa_or_pc_o, rpb_or_imm_o,
    input  alu_write_rf_o, alu_regdest_o, immediate_o,
    input  lsu_ctrl_valid_o, lsu_ctrl_o, lsu_regdest_o, illegal_o,
    input  count_o
  );
endinterface

// File: rtl/rvj1_dec_q.sv
// ---------------------------------------------------------------------------
// rvj1_dec_q -- RV32I (ALU + load/store subset) decoder with a small queue.
//
// Instructions are decoded combinationally as they arrive and only the
// decoded fields (plus an illegal flag) are stored in a DEPTH-entry FIFO.
// The head entry drives the outputs directly, so an instruction accepted
// into an empty queue is visible on the following cycle.
//
// Ports:
//   clk_i  -- clock, all state on the rising edge
//   rst_i  -- asynchronous active-high reset
//   bus    -- rvj1_dec_q_if.slave (fetch handshake, flush, issue handshake,
//             decoded head fields, illegal flag, occupancy count)
//
// Supported opcodes: OP-IMM, OP, LUI, AUIPC, LOAD, STORE. Everything else
// (including compressed encodings, instr[1:0] != 2'b11) is queued as an
// illegal entry carrying NOP fields.
// ---------------------------------------------------------------------------

module rvj1_dec_q #(
  parameter int XLEN  = 32,
  parameter int RALEN = 5,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  rvj1_dec_q_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [RALEN-1:0] rf_addr_a;
    logic [RALEN-1:0] rf_addr_b;
    alu_op_e          alu_sel;
    logic             rpa_or_pc;
    logic             rpb_or_imm;
    logic             alu_write_rf;
    logic [RALEN-1:0] alu_regdest;
    logic [XLEN-1:0]  immediate;
    logic             lsu_ctrl_valid;
    lsu_ctrl_e        lsu_ctrl;
    logic [RALEN-1:0] lsu_regdest;
    logic             illegal;
  } entry_t;

  // All-zero entry: addresses/immediate 0, flags 0, ALU_OP_ADD, LSU_NO_CMD.
  localparam entry_t NOP_ENTRY = '0;

  // -------------------------------------------------------------------------
  // Instruction field extraction
  // -------------------------------------------------------------------------
  logic [XLEN-1:0]  instr;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [RALEN-1:0] rd;
  logic [RALEN-1:0] rs1;
  logic [RALEN-1:0] rs2;
  logic [XLEN-1:0]  imm_i;
  logic [XLEN-1:0]  imm_s;
  logic [XLEN-1:0]  imm_u;

  assign instr  = bus.ifu_instr_i;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u = {instr[31:12], 12'b0};

  // Base ALU operation selected by funct3 for OP / OP-IMM; the alternate
  // funct7 encodings (SUB, SRA) are applied on top of this.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = ALU_OP_ADD;
      3'b001:  op = ALU_OP_SLL;
      3'b010:  op = ALU_OP_SLT;
      3'b011:  op = ALU_OP_SLTU;
      3'b100:  op = ALU_OP_XOR;
      3'b101:  op = ALU_OP_SRL;
      3'b110:  op = ALU_OP_OR;
      default: op = ALU_OP_AND;
    endcase
    return op;
  endfunction

  // -------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // -------------------------------------------------------------------------
  entry_t dec_next;
  logic   legal;

  always_comb begin
    dec_next = NOP_ENTRY;
    legal    = 1'b1;

    if (instr[1:0] != 2'b11) begin
      legal = 1'b0;
    end else begin
      case (opcode)
        OPC_OPIMM: begin
          dec_next.rf_addr_a    = rs1;
          dec_next.alu_regdest  = rd;
          dec_next.immediate    = imm_i;
          dec_next.rpb_or_imm   = 1'b1;
          dec_next.alu_write_rf = 1'b1;
          dec_next.alu_sel      = alu_from_f3(funct3);
          // Only the shift forms constrain the upper immediate bits; for
          // every other funct3 they are just immediate bits.
          case (funct3)
            3'b001: begin
              if (funct7 != F7_BASE) legal = 1'b0;
            end
            3'b101: begin
              if (funct7 == F7_ALT)       dec_next.alu_sel = ALU_OP_SRA;
              else if (funct7 != F7_BASE) legal = 1'b0;
            end
            default: ;
          endcase
        end

        OPC_OP: begin
          dec_next.rf_addr_a    = rs1;
          dec_next.rf_addr_b    = rs2;
          dec_next.alu_regdest  = rd;
          dec_next.alu_write_rf = 1'b1;
          dec_next.alu_sel      = alu_from_f3(funct3);
          if (funct7 == F7_ALT) begin
            case (funct3)
              3'b000:  dec_next.alu_sel = ALU_OP_SUB;
              3'b101:  dec_next.alu_sel = ALU_OP_SRA;
              default: legal = 1'b0;
            endcase
          end else if (funct7 != F7_BASE) begin
            legal = 1'b0;
          end
        end

        OPC_LUI, OPC_AUIPC: begin
          // Computed as rs_a + imm with rs_a forced to x0 (LUI) or PC (AUIPC).
          dec_next.rpa_or_pc    = (opcode == OPC_AUIPC);
          dec_next.alu_regdest  = rd;
          dec_next.immediate    = imm_u;
          dec_next.rpb_or_imm   = 1'b1;
          dec_next.alu_write_rf = 1'b1;
          dec_next.alu_sel      = ALU_OP_ADD;
        end

        OPC_LOAD: begin
          // ALU forms the address; the loaded value is written by the LSU.
          dec_next.rf_addr_a      = rs1;
          dec_next.immediate      = imm_i;
          dec_next.rpb_or_imm     = 1'b1;
          dec_next.alu_sel        = ALU_OP_ADD;
          dec_next.lsu_ctrl_valid = 1'b1;
          dec_next.lsu_regdest    = rd;
          case (funct3)
            3'b000:  dec_next.lsu_ctrl = LSU_LB;
            3'b001:  dec_next.lsu_ctrl = LSU_LH;
            3'b010:  dec_next.lsu_ctrl = LSU_LW;
            3'b100:  dec_next.lsu_ctrl = LSU_LBU;
            3'b101:  dec_next.lsu_ctrl = LSU_LHU;
            default: legal = 1'b0;
          endcase
        end

        OPC_STORE: begin
          dec_next.rf_addr_a      = rs1;
          dec_next.rf_addr_b      = rs2;
          dec_next.immediate      = imm_s;
          dec_next.rpb_or_imm     = 1'b1;
          dec_next.alu_sel        = ALU_OP_ADD;
          dec_next.lsu_ctrl_valid = 1'b1;
          case (funct3)
            3'b000:  dec_next.lsu_ctrl = LSU_SB;
            3'b001:  dec_next.lsu_ctrl = LSU_SH;
            3'b010:  dec_next.lsu_ctrl = LSU_SW;
            default: legal = 1'b0;
          endcase
        end

        default: legal = 1'b0;
      endcase
    end

    // Illegal words still occupy a slot so the issue stage can trap in order.
    if (!legal) begin
      dec_next         = NOP_ENTRY;
      dec_next.illegal = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Queue control
  // -------------------------------------------------------------------------
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  // Holds ifu_ready_o low from reset assertion until the first clock edge
  // after release, independently of the queue state.
  logic          ready_en_reg;

  logic ifu_ready;
  logic out_valid;
  logic enq;
  logic deq;

  // ifu_ready deliberately ignores out_ready_i: a full queue stalls fetch
  // for one cycle even if the head is leaving, keeping the paths separate.
  assign ifu_ready = ready_en_reg && (count_reg < CW'(DEPTH)) && !bus.flush_i;
  assign out_valid = (count_reg != '0);
  assign enq       = bus.ifu_valid_i && ifu_ready;
  assign deq       = out_valid && bus.out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (bus.flush_i) begin
        // Flush wins over a same-cycle dequeue; enqueue is already blocked.
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (enq) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (deq) rd_ptr_reg <= rd_ptr_reg + PW'(1);
        case ({enq, deq})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // Entry storage carries no reset; an entry is only observed once written.
  entry_t mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr_reg] <= dec_next;
  end

  // -------------------------------------------------------------------------
  // Head entry to outputs (NOP whenever the queue is empty, incl. reset)
  // -------------------------------------------------------------------------
  entry_t head;

  assign head = out_valid ? mem[rd_ptr_reg] : NOP_ENTRY;

  assign bus.ifu_ready_o      = ifu_ready;
  assign bus.out_valid_o      = out_valid;
  assign bus.count_o          = count_reg;
  assign bus.rf_addr_a_o      = head.rf_addr_a;
  assign bus.rf_addr_b_o      = head.rf_addr_b;
  assign bus.alu_sel_o        = head.alu_sel;
  assign bus.rpa_or_pc_o      = head.rpa_or_pc;
  assign bus.rpb_or_imm_o     = head.rpb_or_imm;
  assign bus.alu_write_rf_o   = head.alu_write_rf;
  assign bus.alu_regdest_o    = head.alu_regdest;
  assign bus.immediate_o      = head.immediate;
  assign bus.lsu_ctrl_valid_o = head.lsu_ctrl_valid;
  assign bus.lsu_ctrl_o       = head.lsu_ctrl;
  assign bus.lsu_regdest_o    = head.lsu_regdest;
  assign bus.illegal_o        = head.illegal;

endmodule

// File: tb/tb_rvj1_dec_q.sv
// ---------------------------------------------------------------------------
// tb_rvj1_dec_q -- self-checking bench for rvj1_dec_q (DEPTH = 2).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------

module tb_rvj1_dec_q;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [3:0]  alu;
    logic        rpa;
    logic        rpb;
    logic        wrf;
    logic [4:0]  rd_alu;
    logic [31:0] imm;
    logic        lsu_v;
    logic [3:0]  lsu;
    logic [4:0]  rd_lsu;
    logic        ill;
  } exp_t;

  localparam exp_t NOP_E = '0;

  logic clk_i;
  logic rst_i;
  int   n_cmp;
  int   n_err;

  rvj1_dec_q_if #(.XLEN(32), .RALEN(5), .DEPTH(DEPTH)) bus ();

  rvj1_dec_q #(.XLEN(32), .RALEN(5), .DEPTH(DEPTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Snapshot of the decoded outputs as seen by the issue stage.
  function automatic exp_t sample_head();
    exp_t g;
    g.ra     = bus.rf_addr_a_o;
    g.rb     = bus.rf_addr_b_o;
    g.alu    = bus.alu_sel_o;
    g.rpa    = bus.rpa_or_pc_o;
    g.rpb    = bus.rpb_or_imm_o;
    g.wrf    = bus.alu_write_rf_o;
    g.rd_alu = bus.alu_regdest_o;
    g.imm    = bus.immediate_o;
    g.lsu_v  = bus.lsu_ctrl_valid_o;
    g.lsu    = bus.lsu_ctrl_o;
    g.rd_lsu = bus.lsu_regdest_o;
    g.ill    = bus.illegal_o;
    return g;
  endfunction

  // ---------------------------------------------------------------------
  // Reference decoder: straight from the instruction-set rules.
  // ---------------------------------------------------------------------
  function automatic logic [3:0] ref_alu(input logic [2:0] f3);
    case (f3)
      3'd0: return ALU_OP_ADD;
      3'd1: return ALU_OP_SLL;
      3'd2: return ALU_OP_SLT;
      3'd3: return ALU_OP_SLTU;
      3'd4: return ALU_OP_XOR;
      3'd5: return ALU_OP_SRL;
      3'd6: return ALU_OP_OR;
      default: return ALU_OP_AND;
    endcase
  endfunction

  function automatic exp_t model_decode(input logic [31:0] w);
    exp_t e;
    logic ok;
    logic [2:0] f3;
    logic [6:0] f7;
    e  = NOP_E;
    ok = 1'b1;
    f3 = w[14:12];
    f7 = w[31:25];
    if (w[1:0] != 2'b11) ok = 1'b0;
    else begin
      case (w[6:0])
        7'h13: begin
          e.ra = w[19:15]; e.rd_alu = w[11:7]; e.rpb = 1; e.wrf = 1;
          e.imm = {{20{w[31]}}, w[31:20]};
          e.alu = ref_alu(f3);
          if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
          if (f3 == 3'd5) begin
            if (f7 == 7'h20) e.alu = ALU_OP_SRA;
            else if (f7 != 7'h00) ok = 1'b0;
          end
        end
        7'h33: begin
          e.ra = w[19:15]; e.rb = w[24:20]; e.rd_alu = w[11:7]; e.wrf = 1;
          e.alu = ref_alu(f3);
          if (f7 == 7'h20) begin
            if (f3 == 3'd0) e.alu = ALU_OP_SUB;
            else if (f3 == 3'd5) e.alu = ALU_OP_SRA;
            else ok = 1'b0;
          end else if (f7 != 7'h00) ok = 1'b0;
        end
        7'h37, 7'h17: begin
          e.rpa = (w[6:0] == 7'h17); e.rd_alu = w[11:7];
          e.imm = {w[31:12], 12'h000}; e.rpb = 1; e.wrf = 1;
          e.alu = ALU_OP_ADD;
        end
        7'h03: begin
          e.ra = w[19:15]; e.imm = {{20{w[31]}}, w[31:20]}; e.rpb = 1;
          e.alu = ALU_OP_ADD; e.lsu_v = 1; e.rd_lsu = w[11:7];
          case (f3)
            3'd0: e.lsu = LSU_LB;
            3'd1: e.lsu = LSU_LH;
            3'd2: e.lsu = LSU_LW;
            3'd4: e.lsu = LSU_LBU;
            3'd5: e.lsu = LSU_LHU;
            default: ok = 1'b0;
          endcase
        end
        7'h23: begin
          e.ra = w[19:15]; e.rb = w[24:20];
          e.imm = {{20{w[31]}}, w[31:25], w[11:7]}; e.rpb = 1;
          e.alu = ALU_OP_ADD; e.lsu_v = 1;
          case (f3)
            3'd0: e.lsu = LSU_SB;
            3'd1: e.lsu = LSU_SH;
            3'd2: e.lsu = LSU_SW;
            default: ok = 1'b0;
          endcase
        end
        default: ok = 1'b0;
      endcase
    end
    if (!ok) begin
      e = NOP_E;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Mostly well-formed opcodes with funct7 biased toward meaningful values,
  // plus fully random words to exercise illegal handling.
  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [6];
    ops = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h03, 7'h23};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) begin
      w[6:0] = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    end
    return w;
  endfunction

  task automatic idle_inputs();
    bus.ifu_valid_i = 1'b0;
    bus.ifu_instr_i = '0;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    exp_t g;
    rst_i = 1'b1;
    idle_inputs();
    #3;
    n_cmp++; if (bus.count_o !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count_o); end
    n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.out_valid_o); end
    n_cmp++; if (bus.ifu_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", bus.ifu_ready_o); end
    g = sample_head();
    n_cmp++; if (g !== NOP_E) begin n_err++; $display("FAIL reset_nop: got %h want %h", g, NOP_E); end
    @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
    n_cmp++; if (bus.ifu_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready_held: got %b want 0", bus.ifu_ready_o); end
    #2 rst_i = 1'b0;
    #1;
    n_cmp++; if (bus.ifu_ready_o !== 1'b0) begin n_err++; $display("FAIL ready_before_edge: got %b want 0", bus.ifu_ready_o); end
    @(posedge clk_i); #1;
    n_cmp++; if (bus.ifu_ready_o !== 1'b1) begin n_err++; $display("FAIL ready_after_edge: got %b want 1", bus.ifu_ready_o); end
    $display("reset: done");
  endtask

  // ---------------------------------------------------------------------
  task automatic test_decode_vectors();
    logic [31:0] vec [5];
    exp_t        want [5];
    exp_t        g;
    vec = '{32'h00500093, 32'h402081B3, 32'h40000093, 32'h00812283, 32'hFFFFFFFF};
    want[0] = NOP_E; want[0].rd_alu = 5'd1; want[0].imm = 32'd5; want[0].rpb = 1; want[0].wrf = 1; want[0].alu = ALU_OP_ADD;
    want[1] = NOP_E; want[1].ra = 5'd1; want[1].rb = 5'd2; want[1].rd_alu = 5'd3; want[1].wrf = 1; want[1].alu = ALU_OP_SUB;
    want[2] = NOP_E; want[2].rd_alu = 5'd1; want[2].imm = 32'h400; want[2].rpb = 1; want[2].wrf = 1; want[2].alu = ALU_OP_ADD;
    want[3] = NOP_E; want[3].ra = 5'd2; want[3].imm = 32'd8; want[3].rpb = 1; want[3].alu = ALU_OP_ADD;
    want[3].lsu_v = 1; want[3].lsu = LSU_LW; want[3].rd_lsu = 5'd5;
    want[4] = NOP_E; want[4].ill = 1;
    for (int i = 0; i < 5; i++) begin
      bus.ifu_valid_i = 1'b1;
      bus.ifu_instr_i = vec[i];
      bus.out_ready_i = 1'b1;
      @(posedge clk_i); #1;
      bus.ifu_valid_i = 1'b0;
      @(negedge clk_i);
      g = sample_head();
      n_cmp++; if (bus.out_valid_o !== 1'b1) begin n_err++; $display("FAIL vec%0d_valid: got %b want 1", i, bus.out_valid_o); end
      n_cmp++; if (g !== want[i]) begin n_err++; $display("FAIL vec%0d_fields: got %h want %h", i, g, want[i]); end
      $display("decode: instr %h -> fields %h", vec[i], g);
      @(posedge clk_i); #1;
    end
    n_cmp++; if (bus.count_o !== '0) begin n_err++; $display("FAIL vec_drain_count: got %0d want 0", bus.count_o); end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [31:0] a, b, c;
    exp_t g;
    a = 32'h00100093; // addi x1, x0, 1
    b = 32'h00200113; // addi x2, x0, 2
    c = 32'h00300193; // addi x3, x0, 3
    bus.out_ready_i = 1'b0;
    bus.ifu_valid_i = 1'b1;
    bus.ifu_instr_i = a;
    @(posedge clk_i); #1; bus.ifu_instr_i = b;
    @(posedge clk_i); #1; bus.ifu_instr_i = c;
    @(negedge clk_i);
    n_cmp++; if (bus.ifu_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", bus.ifu_ready_o); end
    n_cmp++; if (bus.count_o !== CW'(2)) begin n_err++; $display("FAIL full_count: got %0d want 2", bus.count_o); end
    @(posedge clk_i); #1;
    bus.ifu_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk_i);
    g = sample_head();
    n_cmp++; if (bus.count_o !== CW'(2)) begin n_err++; $display("FAIL third_rejected: got count %0d want 2", bus.count_o); end
    n_cmp++; if (g !== model_decode(a)) begin n_err++; $display("FAIL order_first: got %h want %h", g, model_decode(a)); end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    g = sample_head();
    n_cmp++; if (g !== model_decode(b)) begin n_err++; $display("FAIL order_second: got %h want %h", g, model_decode(b)); end
    n_cmp++; if (bus.ifu_ready_o !== 1'b1) begin n_err++; $display("FAIL ready_after_deq: got %b want 1", bus.ifu_ready_o); end
    n_cmp++; if (bus.count_o !== CW'(1)) begin n_err++; $display("FAIL count_after_deq: got %0d want 1", bus.count_o); end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL drained_valid: got %b want 0", bus.out_valid_o); end
    $display("back_to_back: checked");
    @(posedge clk_i); #1;
    idle_inputs();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_flush();
    bus.out_ready_i = 1'b0;
    bus.ifu_valid_i = 1'b1;
    bus.ifu_instr_i = 32'h00100093;
    @(posedge clk_i); #1; bus.ifu_instr_i = 32'h00200113;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    n_cmp++; if (bus.count_o !== CW'(2)) begin n_err++; $display("FAIL preflush_count: got %0d want 2", bus.count_o); end
    bus.flush_i     = 1'b1;
    bus.ifu_instr_i = 32'h00300193;
    bus.out_ready_i = 1'b1;
    #1;
    n_cmp++; if (bus.ifu_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", bus.ifu_ready_o); end
    @(posedge clk_i); #1;
    idle_inputs();
    @(negedge clk_i);
    n_cmp++; if (bus.count_o !== '0) begin n_err++; $display("FAIL flush_count: got %0d want 0", bus.count_o); end
    n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", bus.out_valid_o); end
    $display("flush: count after flush %0d", bus.count_o);
    @(posedge clk_i); #1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_async_reset();
    exp_t g;
    bus.out_ready_i = 1'b0;
    bus.ifu_valid_i = 1'b1;
    bus.ifu_instr_i = 32'h00812283;
    @(posedge clk_i); #1;
    bus.ifu_valid_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (bus.count_o !== CW'(1)) begin n_err++; $display("FAIL prereset_count: got %0d want 1", bus.count_o); end
    #2 rst_i = 1'b1;
    #1;
    g = sample_head();
    n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", bus.out_valid_o); end
    n_cmp++; if (bus.count_o !== '0) begin n_err++; $display("FAIL async_count: got %0d want 0", bus.count_o); end
    n_cmp++; if (bus.ifu_ready_o !== 1'b0) begin n_err++; $display("FAIL async_ready: got %b want 0", bus.ifu_ready_o); end
    n_cmp++; if (g !== NOP_E) begin n_err++; $display("FAIL async_nop: got %h want %h", g, NOP_E); end
    @(posedge clk_i); @(negedge clk_i);
    #2 rst_i = 1'b0;
    @(posedge clk_i); #1;
    n_cmp++; if (bus.ifu_ready_o !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", bus.ifu_ready_o); end
    n_cmp++; if (bus.count_o !== '0) begin n_err++; $display("FAIL post_reset_count: got %0d want 0", bus.count_o); end
    $display("async_reset: checked");
  endtask

  // ---------------------------------------------------------------------
  task automatic test_random(input int cycles);
    exp_t        q [$];
    exp_t        want;
    exp_t        g;
    logic        v, r, f, exp_ready;
    logic [31:0] w;
    for (int c = 0; c < cycles; c++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 24) == 0);
      w = rand_instr();
      bus.ifu_valid_i = v;
      bus.ifu_instr_i = w;
      bus.out_ready_i = r;
      bus.flush_i     = f;
      @(negedge clk_i);
      exp_ready = (q.size() < DEPTH) && !f;
      want = (q.size() != 0) ? q[0] : NOP_E;
      g = sample_head();
      n_cmp++; if (bus.ifu_ready_o !== exp_ready) begin n_err++; $display("FAIL rnd%0d_ready: got %b want %b", c, bus.ifu_ready_o, exp_ready); end
      n_cmp++; if (bus.out_valid_o !== (q.size() != 0)) begin n_err++; $display("FAIL rnd%0d_valid: got %b want %b", c, bus.out_valid_o, q.size() != 0); end
      n_cmp++; if (bus.count_o !== CW'(q.size())) begin n_err++; $display("FAIL rnd%0d_count: got %0d want %0d", c, bus.count_o, q.size()); end
      n_cmp++; if (g !== want) begin n_err++; $display("FAIL rnd%0d_head: got %h want %h", c, g, want); end
      $display("random %0d: v=%b r=%b f=%b instr=%h count=%0d head=%h", c, v, r, f, w, bus.count_o, g);
      @(posedge clk_i);
      if (f) q.delete();
      else begin
        if (q.size() != 0 && r) void'(q.pop_front());
        if (v && exp_ready) q.push_back(model_decode(w));
      end
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_decode_vectors();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
